// File: rtl/aes_byte_serializer_if.sv
// Handshake bundle for the AES byte serializer: block-wide input side and
// byte-wide output side, plus status.
interface aes_byte_serializer_if #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned BYTE_W  = 8,
  parameter int unsigned IDX_W   = $clog2(BLOCK_W / BYTE_W)
);
  logic [BLOCK_W-1:0] in_block;
  logic               in_valid;
  logic               in_ready;
  logic [BYTE_W-1:0]  out_byte;
  logic               out_valid;
  logic               out_ready;
  logic               out_first;
  logic               out_last;
  logic [IDX_W-1:0]   out_idx;
  logic               busy;

  // Block producer / byte consumer side
  modport master (
    output in_block,
    output in_valid,
    input  in_ready,
    input  out_byte,
    input  out_valid,
    output out_ready,
    input  out_first,
    input  out_last,
    input  out_idx,
    input  busy
  );

  // Serializer side
  modport slave (
    input  in_block,
    input  in_valid,
    output in_ready,
    output out_byte,
    output out_valid,
    input  out_ready,
    output out_first,
    output out_last,
    output out_idx,
    output busy
  );
endinterface

// File: rtl/aes_byte_serializer.sv
// Byte-serial transmitter for 128-bit AES blocks. Accepts a whole block and
// emits it MSB byte first. A single pending buffer lets the next block be
// taken while the current one streams, so consecutive blocks have no gap.
module aes_byte_serializer #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned BYTE_W  = 8
) (
  input logic                  clk,
  input logic                  rst,
  aes_byte_serializer_if.slave bus
);

  localparam int unsigned NBYTES = BLOCK_W / BYTE_W;
  localparam int unsigned IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NBYTES - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] shift_q, shift_d;
  logic [BLOCK_W-1:0] pend_q, pend_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pend_full_q, pend_full_d;

  logic send;
  logic in_ready;
  logic accept;
  logic xfer;
  logic last_xfer;

  assign send      = (state_q == StSend);
  assign in_ready  = !rst && !pend_full_q;
  assign accept    = bus.in_valid && in_ready;
  assign xfer      = send && bus.out_ready;
  assign last_xfer = xfer && (idx_q == LastIdx);

  // Outputs are forced to zero outside SEND so reset clears them at once
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = send;
  assign bus.out_byte  = send ? shift_q[BLOCK_W-1 -: BYTE_W] : '0;
  assign bus.out_idx   = send ? idx_q : '0;
  assign bus.out_first = send && (idx_q == '0);
  assign bus.out_last  = send && (idx_q == LastIdx);
  assign bus.busy      = send || pend_full_q;

  // Next-state: load, shift, pending-buffer refill and bypass
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    idx_d       = idx_q;
    pend_full_d = pend_full_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = bus.in_block;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        // An accept on the last beat bypasses the pending buffer
        if (accept && !last_xfer) begin
          pend_d      = bus.in_block;
          pend_full_d = 1'b1;
        end
        if (xfer) begin
          if (!last_xfer) begin
            shift_d = shift_q << BYTE_W;
            idx_d   = idx_q + IDX_W'(1);
          end else if (pend_full_q) begin
            shift_d     = pend_q;
            pend_full_d = 1'b0;
            idx_d       = '0;
          end else if (accept) begin
            shift_d = bus.in_block;
            idx_d   = '0;
          end else begin
            idx_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      pend_q      <= '0;
      idx_q       <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      pend_full_q <= pend_full_d;
    end
  end

endmodule
